// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// State encodings are plain constants so legacy code can still compare against them.
package dmem_arb_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t ACCESS = 2'd1;
    localparam state_t DONE   = 2'd2;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester handshake and data-memory bus shared by the arbiter and its environment.
// slave is the arbiter's view; master is the requesters plus memory.
interface dmem_arbiter_if #(
    parameter int DATA_W = dmem_arb_pkg::DATA_W,
    parameter int ADDR_W = dmem_arb_pkg::ADDR_W
);
    import dmem_arb_pkg::*;

    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic [ADDR_W-1:0] mem_access_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_en;
    logic              mem_read;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata, err,
        output mem_access_addr, mem_write_data, mem_write_en, mem_read,
        input  mem_read_data
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata, err,
        input  mem_access_addr, mem_write_data, mem_write_en, mem_read,
        output mem_read_data
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way picker: round-robin on a tie when enabled, else port 0 wins.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last_served,
    input  logic       i_rr_en,
    output logic [1:0] o_grant,
    output logic       o_idx
);
    import dmem_arb_pkg::*;

    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = (i_rr_en && (i_last_served == PORT_CPU)) ? 2'b10 : 2'b01;
        end
        o_idx = o_grant[1] ? PORT_DMA : PORT_CPU;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU and DMA ports onto the single-port data memory: IDLE -> ACCESS -> DONE,
// with a one-cycle ack carrying registered read data and an out-of-range flag.
module dmem_arbiter #(
    parameter int DATA_W = dmem_arb_pkg::DATA_W,
    parameter int ADDR_W = dmem_arb_pkg::ADDR_W,
    parameter int DEPTH  = 8,
    parameter bit RR_EN  = 1'b1
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    import dmem_arb_pkg::*;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    state_t            r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_idx;
    logic              r_last;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic [1:0]        w_grant;
    logic              w_gidx;
    logic              w_access;
    logic              w_in_range;
    logic              w_rd_hit;

    rr_arb2 u_arb (
        .i_req         ({bus.req1, bus.req0}),
        .i_last_served (r_last),
        .i_rr_en       (RR_EN),
        .o_grant       (w_grant),
        .o_idx         (w_gidx)
    );

    assign w_access   = (r_state == ACCESS);
    assign w_in_range = (r_addr < DEPTH_A);
    assign w_rd_hit   = !r_we && w_in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_idx   <= PORT_CPU;
            r_last  <= PORT_DMA;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_we    <= w_grant[1] ? bus.we1    : bus.we0;
                        r_addr  <= w_grant[1] ? bus.addr1  : bus.addr0;
                        r_wdata <= w_grant[1] ? bus.wdata1 : bus.wdata0;
                        r_idx   <= w_gidx;
                        r_last  <= w_gidx;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_rdata <= w_rd_hit ? bus.mem_read_data : '0;
                    r_err   <= !w_in_range;
                    r_state <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_access_addr = w_access ? r_addr  : '0;
    assign bus.mem_write_data  = w_access ? r_wdata : '0;
    // A reset landing on the strobe edge must not let the aborted write reach memory.
    assign bus.mem_write_en    = w_access && r_we && w_in_range && !rst;
    assign bus.mem_read        = w_access && w_rd_hit;

    assign bus.ack0  = (r_state == DONE) && (r_idx == PORT_CPU);
    assign bus.ack1  = (r_state == DONE) && (r_idx == PORT_DMA);
    assign bus.rdata = r_rdata;
    assign bus.err   = r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance (A) and a fixed-priority
// instance (B), each with its own 8-word memory model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clr = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_W(16), .ADDR_W(16)) busA ();
    dmem_arbiter_if #(.DATA_W(16), .ADDR_W(16)) busB ();

    dmem_arbiter #(.DATA_W(16), .ADDR_W(16), .DEPTH(8), .RR_EN(1'b1)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    dmem_arbiter #(.DATA_W(16), .ADDR_W(16), .DEPTH(8), .RR_EN(1'b0)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    logic [15:0] memA [0:7];
    logic [15:0] memB [0:7];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 8; i++) begin
                memA[i] <= '0;
                memB[i] <= '0;
            end
        end else begin
            if (busA.mem_write_en) memA[busA.mem_access_addr[2:0]] <= busA.mem_write_data;
            if (busB.mem_write_en) memB[busB.mem_access_addr[2:0]] <= busB.mem_write_data;
        end
    end

    assign busA.mem_read_data = memA[busA.mem_access_addr[2:0]];
    assign busB.mem_read_data = memB[busB.mem_access_addr[2:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reqA(input bit p, input bit we, input logic [15:0] a, input logic [15:0] d);
        if (!p) begin
            busA.we0 = we; busA.addr0 = a; busA.wdata0 = d; busA.req0 = 1'b1;
        end else begin
            busA.we1 = we; busA.addr1 = a; busA.wdata1 = d; busA.req1 = 1'b1;
        end
    endtask

    task automatic dropA(input bit p);
        if (!p) busA.req0 = 1'b0;
        else    busA.req1 = 1'b0;
    endtask

    // One complete access on instance A, checked cycle by cycle.
    task automatic accA(input string tag, input bit p, input bit we, input logic [15:0] a,
                        input logic [15:0] d, input bit exp_strobe, input logic [15:0] exp_rd,
                        input bit exp_err);
        reqA(p, we, a, d);
        step();
        chk({tag, "_wen"},  32'(busA.mem_write_en), 32'(we & exp_strobe));
        chk({tag, "_rdEn"}, 32'(busA.mem_read), 32'(!we & exp_strobe));
        chk({tag, "_addr"}, 32'(busA.mem_access_addr), 32'(a));
        if (we) chk({tag, "_wdata"}, 32'(busA.mem_write_data), 32'(d));
        chk({tag, "_ackEarly"}, 32'({busA.ack1, busA.ack0}), 0);
        step();
        chk({tag, "_ack"}, 32'({busA.ack1, busA.ack0}), p ? 2 : 1);
        chk({tag, "_strobeOff"}, 32'({busA.mem_write_en, busA.mem_read}), 0);
        if (!we) chk({tag, "_rdata"}, 32'(busA.rdata), 32'(exp_rd));
        chk({tag, "_err"}, 32'(busA.err), 32'(exp_err));
        dropA(p);
        step();
        chk({tag, "_ackOff"}, 32'({busA.ack1, busA.ack0}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          na;
        int          nb;
        logic [3:0]  seqA;
        logic [3:0]  seqB;

        {busA.req0, busA.req1, busA.we0, busA.we1} = '0;
        {busA.addr0, busA.addr1, busA.wdata0, busA.wdata1} = '0;
        {busB.req0, busB.req1, busB.we0, busB.we1} = '0;
        {busB.addr0, busB.addr1, busB.wdata0, busB.wdata1} = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",   32'({busA.ack1, busA.ack0}), 0);
        chk("rst_err",   32'(busA.err), 0);
        chk("rst_rdata", 32'(busA.rdata), 0);
        chk("rst_wen",   32'(busA.mem_write_en), 0);
        chk("rst_rd",    32'(busA.mem_read), 0);
        chk("rst_addr",  32'(busA.mem_access_addr), 0);
        chk("rst_wdata", 32'(busA.mem_write_data), 0);
        chk("rst_ackB",  32'({busB.ack1, busB.ack0}), 0);
        rst = 1'b0;
        mem_clr = 1'b0;

        accA("wr3", 1'b0, 1'b1, 16'd3, 16'hA5A5, 1'b1, 16'h0000, 1'b0);
        chk("mem3", 32'(memA[3]), 32'hA5A5);
        accA("rd3", 1'b0, 1'b0, 16'd3, 16'h0000, 1'b1, 16'hA5A5, 1'b0);

        // Simultaneous requests straight after reset: port 0 first, port 1 three cycles later.
        rst = 1'b1;
        step();
        rst = 1'b0;
        reqA(1'b0, 1'b0, 16'd3, 16'h0000);
        reqA(1'b1, 1'b1, 16'd5, 16'h1234);
        step();
        chk("sim_rd0", 32'(busA.mem_read), 1);
        step();
        chk("sim_ack0", 32'({busA.ack1, busA.ack0}), 1);
        chk("sim_rdata0", 32'(busA.rdata), 32'hA5A5);
        dropA(1'b0);
        step();
        chk("sim_idle", 32'({busA.ack1, busA.ack0}), 0);
        step();
        chk("sim_wen1", 32'(busA.mem_write_en), 1);
        chk("sim_addr1", 32'(busA.mem_access_addr), 5);
        step();
        chk("sim_ack1", 32'({busA.ack1, busA.ack0}), 2);
        dropA(1'b1);
        step();
        chk("sim_ackOff", 32'({busA.ack1, busA.ack0}), 0);
        chk("mem5", 32'(memA[5]), 32'h1234);

        // Both ports hold requests for 12 cycles on both instances.
        reqA(1'b0, 1'b0, 16'd3, 16'h0000);
        reqA(1'b1, 1'b0, 16'd5, 16'h0000);
        busB.addr0 = 16'd1; busB.addr1 = 16'd2; busB.req0 = 1'b1; busB.req1 = 1'b1;
        na = 0; nb = 0; seqA = '0; seqB = '1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (busA.ack0 | busA.ack1) begin
                chk("rrA_overlap", 32'(busA.ack0 & busA.ack1), 0);
                if (na < 4) seqA[na] = busA.ack1;
                na++;
            end
            if (busB.ack0 | busB.ack1) begin
                chk("rrB_overlap", 32'(busB.ack0 & busB.ack1), 0);
                if (nb < 4) seqB[nb] = busB.ack1;
                nb++;
            end
        end
        chk("rrA_count", 32'(na), 4);
        chk("rrA_seq",   32'(seqA), 32'b1010);
        chk("rrB_count", 32'(nb), 4);
        chk("rrB_seq",   32'(seqB), 0);
        dropA(1'b0);
        dropA(1'b1);
        busB.req0 = 1'b0; busB.req1 = 1'b0;
        step();

        accA("oor_rd8",  1'b0, 1'b0, 16'd8,     16'h0000, 1'b0, 16'h0000, 1'b1);
        accA("oor_wr9",  1'b0, 1'b1, 16'd9,     16'hFFFF, 1'b0, 16'h0000, 1'b1);
        chk("mem1_keep", 32'(memA[1]), 0);
        accA("edge_wr7", 1'b1, 1'b1, 16'd7,     16'h7777, 1'b1, 16'h0000, 1'b0);
        chk("mem7", 32'(memA[7]), 32'h7777);
        accA("edge_rd7", 1'b0, 1'b0, 16'd7,     16'h0000, 1'b1, 16'h7777, 1'b0);
        accA("hi_rd",    1'b1, 1'b0, 16'h0103, 16'h0000, 1'b0, 16'h0000, 1'b1);

        // Reset lands on the ACCESS edge of a read; the held request is served again.
        reqA(1'b0, 1'b0, 16'd3, 16'h0000);
        step();
        chk("rmid_rd", 32'(busA.mem_read), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rmid_ack",   32'({busA.ack1, busA.ack0}), 0);
        chk("rmid_err",   32'(busA.err), 0);
        chk("rmid_rdata", 32'(busA.rdata), 0);
        chk("rmid_strb",  32'({busA.mem_write_en, busA.mem_read}), 0);
        chk("rmid_addr",  32'(busA.mem_access_addr), 0);
        step();
        chk("rmid_reRd", 32'(busA.mem_read), 1);
        step();
        chk("rmid_reAck",   32'({busA.ack1, busA.ack0}), 1);
        chk("rmid_reRdata", 32'(busA.rdata), 32'hA5A5);
        dropA(1'b0);
        step();

        // Write aborted by reset on its strobe edge must not reach memory.
        reqA(1'b1, 1'b1, 16'd2, 16'hDEAD);
        step();
        chk("wabort_wenPre", 32'(busA.mem_write_en), 1);
        rst = 1'b1;
        #1;
        chk("wabort_wenRst", 32'(busA.mem_write_en), 0);
        step();
        rst = 1'b0;
        dropA(1'b1);
        chk("wabort_ack", 32'({busA.ack1, busA.ack0}), 0);
        step();
        chk("wabort_ack2", 32'({busA.ack1, busA.ack0}), 0);
        chk("mem2_keep", 32'(memA[2]), 0);

        // req1 dropped during ACCESS still gets its ack.
        reqA(1'b1, 1'b1, 16'd6, 16'h0BEE);
        step();
        dropA(1'b1);
        chk("drop_wen", 32'(busA.mem_write_en), 1);
        step();
        chk("drop_ack", 32'({busA.ack1, busA.ack0}), 2);
        step();
        chk("drop_ackOff", 32'({busA.ack1, busA.ack0}), 0);
        step();
        chk("drop_idle", 32'({busA.mem_write_en, busA.mem_read}), 0);
        chk("mem6", 32'(memA[6]), 32'h0BEE);
        accA("rd6", 1'b1, 1'b0, 16'd6, 16'h0000, 1'b1, 16'h0BEE, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the 16-bit processor's single-port data memory. It shares the memory between the CPU load/store unit (port 0) and a DMA/debug port (port 1). Requests are serialised through a three-state FSM, and each access is completed with a one-cycle acknowledge carrying registered read data. The block sits between both requesters and the data memory's shared address, write and read-enable port.

## Interface
- DATA_W, 16, data word width
- ADDR_W, 16, address width
- DEPTH, 8, number of valid memory words; addresses >= DEPTH are out of range
- RR_EN, 1, 1 = round-robin arbitration, 0 = fixed priority (port 0 wins)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request, held until the matching ack
- we0 / we1  in  1  1 = write, 0 = read; stable while req is high
- addr0 / addr1  in  ADDR_W  word address; stable while req is high
- wdata0 / wdata1  in  DATA_W  write data; stable while req is high
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read data, valid in the ack cycle, shared by both ports
- err  out  1  out-of-range flag, valid in the ack cycle
- mem_access_addr  out  ADDR_W  memory address
- mem_write_data  out  DATA_W  memory write data
- mem_write_en  out  1  memory write strobe
- mem_read  out  1  memory read enable
- mem_read_data  in  DATA_W  memory read data, combinational from the memory

## Operation
- FSM states are IDLE, ACCESS and DONE. Reset state is IDLE.
- **IDLE:** if any req is high, the arbiter picks a winner. It latches the winner's we, addr and wdata and the winner's index, then moves to ACCESS. With no request it stays in IDLE.
- **ACCESS:** the arbiter drives mem_access_addr from the latched address.
  - Write: mem_write_en = 1, and mem_write_data carries the latched data.
  - Read: mem_read = 1, and rdata is captured from mem_read_data at the end of this cycle.
  - Out of range (addr >= DEPTH): mem_write_en and mem_read stay 0, rdata is captured as 0, and err is set.
  - The state then moves to DONE.
- **DONE:** the winner's ack is 1. rdata and err hold the values captured for this access. The next state is always IDLE.
- **Arbitration with RR_EN=1:**
  - When both ports request, the port not served last wins.
  - last_served resets to 1, so port 0 wins the first tie.
  - last_served updates only on entry to ACCESS.
- **Arbitration with RR_EN=0:** port 0 always wins a tie.
- Protocol violation: if req drops during ACCESS or DONE, the access still completes and ack still pulses.
- Addresses wider than the memory index are passed through unchanged. The memory decodes only the low bits. The range check uses the full ADDR_W.

## Timing
- Reset values: ack0 = ack1 = 0, err = 0, rdata = 0, mem_write_en = 0, mem_read = 0, mem_access_addr = 0, mem_write_data = 0.
- Latency: req sampled in IDLE at cycle N, memory access at N+1, ack at N+2, IDLE again at N+3.
- A requester drops req in the cycle after ack. A req still high at N+3 counts as a new request.
- Maximum throughput is one access per 3 cycles. Back-to-back requests from both ports alternate under RR_EN=1.
- mem_write_en and mem_read are high only in ACCESS, for exactly one cycle per access.
- rst asserted in any state returns the FSM to IDLE at that edge. All outputs take their reset values from the next cycle. A write interrupted in ACCESS completes only if its strobe cycle's edge is not the reset edge. No ack is issued for an aborted access.
- The memory read path is combinational. rdata is registered, so there is no combinational path from mem_read_data to the requester outputs.

## Structure
- Package dmem_arb_pkg holds:
  - the state typedef (IDLE, ACCESS, DONE);
  - the port-index constants PORT_CPU = 0 and PORT_DMA = 1;
  - the default width constants DATA_W = 16 and ADDR_W = 16.
- Sub-module rr_arb2: a combinational two-way picker. Inputs are req[1:0], last_served and rr_en. Outputs are grant[1:0] (one-hot) and the grant index. The top level contains the FSM, the command latch and the rdata/err registers.

## Test plan
- **Single CPU write then read:** req0, we0=1, addr0=3, wdata0=16'hA5A5, then a read of addr 3 → mem_write_en high for one cycle at N+1, ack0 at N+2, later read ack0 with rdata=16'hA5A5, err=0.
- **Simultaneous requests after reset:** req0 and req1 both high from IDLE → port 0 served first (ack0 at N+2). Port 1 is then served with ack1 at N+5, and ack0/ack1 never overlap.
- **Round-robin fairness:** both ports hold continuous requests for 12 cycles with RR_EN=1 → grants alternate 0,1,0,1. With RR_EN=0 and port 0 re-requesting immediately, port 0 wins every tie.
- **Out of range:** read at addr=16'd8 with DEPTH=8 → mem_read stays 0, ack with rdata=0 and err=1. A write to addr 9 → mem_write_en stays 0 and memory contents are unchanged.
- **Reset mid-operation:** rst asserted in ACCESS of a read → no ack pulse, the FSM is in IDLE next cycle, all outputs at reset values. A held req is then re-served normally.
- **Early req drop:** req1 dropped in ACCESS → ack1 still pulses at N+2, and the FSM returns to IDLE.
